// File: rtl/nand_dqs_calib_ctrl.sv
// DQS read-capture calibration sequencer for one NAND PHY channel.
// Sweeps the DQS IDELAY tap, pattern-checks each tap, then loads the window centre.
module nand_dqs_calib_ctrl #(
    parameter int                  DQ_WIDTH      = 8,
    parameter int                  NUM_TAPS      = 32,
    parameter int                  SETTLE_CYCLES = 16,
    parameter int                  BEATS         = 4,
    parameter logic [DQ_WIDTH-1:0] PAT_RISE      = 8'hA5,
    parameter logic [DQ_WIDTH-1:0] PAT_FALL      = 8'h5A,
    parameter int                  TIMEOUT       = 255,
    parameter int                  DEFAULT_TAP   = 16
) (
    input  logic                v_clk0,
    input  logic                v_rstn0,
    input  logic                cal_start,
    output logic                cal_busy,
    output logic                cal_done,
    output logic                cal_fail,
    output logic [4:0]          cal_tap,
    output logic [31:0]         pass_map,
    output logic [4:0]          v_dlyval_dqs,
    output logic                v_dlyld_dqs,
    input  logic [4:0]          v_dlyvalout_dqs,
    output logic                v_dq_iddr_rst,
    output logic                rd_req,
    input  logic                rd_ack,
    input  logic                rd_beat_valid,
    input  logic [DQ_WIDTH-1:0] v_rd_data_rise,
    input  logic [DQ_WIDTH-1:0] v_rd_data_fall
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(BEATS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST   = BW'(BEATS - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [4:0]    LAST_TAP    = 5'(NUM_TAPS - 1);
    localparam logic [4:0]    DEF_TAP     = 5'(DEFAULT_TAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_REQ,
        S_CHECK,
        S_NEXT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [4:0]    r_tap;
    logic          r_tap_ok;
    logic [SW-1:0] r_settle_cnt;
    logic [BW-1:0] r_beat_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [31:0]   r_pass_map;
    logic [4:0]    r_cur_start;
    logic [5:0]    r_cur_len;
    logic [4:0]    r_best_start;
    logic [5:0]    r_best_len;
    logic [4:0]    r_cal_tap;
    logic          r_cal_fail;
    logic          r_cal_done;
    logic          r_cal_busy;
    logic [4:0]    r_dlyval;

    logic          w_settle_last;
    logic          w_to_hit;
    logic          w_beat_ok;
    logic          w_beat_last;
    logic          w_last_tap;
    logic          w_rb_bad;
    logic [5:0]    w_cur_len_nxt;
    logic [4:0]    w_cur_start_nxt;
    logic [4:0]    w_half;
    logic [4:0]    w_final_tap;
    logic [4:0]    w_dlyval;
    logic          w_dlyld;
    logic          w_iddr_rst;
    logic          w_rd_req;

    assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
    assign w_to_hit      = (r_to_cnt == TO_LAST);
    assign w_beat_ok     = (v_rd_data_rise == PAT_RISE) &&
                           (v_rd_data_fall == PAT_FALL);
    assign w_beat_last   = rd_beat_valid && (r_beat_cnt == BEAT_LAST);
    assign w_last_tap    = (r_tap == LAST_TAP);
    assign w_rb_bad      = (v_dlyvalout_dqs != r_tap);

    assign w_cur_len_nxt   = r_tap_ok ? (r_cur_len + 6'd1) : 6'd0;
    assign w_cur_start_nxt = (r_tap_ok && (r_cur_len == 6'd0)) ?
                             r_tap : r_cur_start;

    // Floor of the window centre; an empty window falls back to the default.
    assign w_half      = 5'((r_best_len - 6'd1) >> 1);
    assign w_final_tap = (r_best_len == 6'd0) ? DEF_TAP :
                         (r_best_start + w_half);

    // State register
    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cal_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_last) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (rd_ack)
                    w_state_nxt = S_CHECK;
                else if (w_to_hit)
                    w_state_nxt = S_NEXT;
            end
            S_CHECK: begin
                if (w_beat_last)
                    w_state_nxt = S_NEXT;
                else if (!rd_beat_valid && w_to_hit)
                    w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                w_state_nxt = w_last_tap ? S_FINAL : S_LOAD;
            end
            S_FINAL: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic; the delay port is driven only in LOAD and FINAL
    always_comb begin
        w_dlyval   = r_dlyval;
        w_dlyld    = 1'b0;
        w_iddr_rst = 1'b0;
        w_rd_req   = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_dlyval   = r_tap;
                w_dlyld    = 1'b1;
                w_iddr_rst = 1'b1;
            end
            S_FINAL: begin
                w_dlyval = w_final_tap;
                w_dlyld  = 1'b1;
            end
            S_REQ: begin
                w_rd_req = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: tap, counters, pass map, window tracking, result
    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            r_tap        <= 5'd0;
            r_tap_ok     <= 1'b0;
            r_settle_cnt <= '0;
            r_beat_cnt   <= '0;
            r_to_cnt     <= '0;
            r_pass_map   <= 32'd0;
            r_cur_start  <= 5'd0;
            r_cur_len    <= 6'd0;
            r_best_start <= 5'd0;
            r_best_len   <= 6'd0;
            r_cal_tap    <= DEF_TAP;
            r_cal_fail   <= 1'b0;
            r_cal_done   <= 1'b0;
            r_cal_busy   <= 1'b0;
            r_dlyval     <= DEF_TAP;
        end else begin
            r_dlyval <= w_dlyval;
            unique case (r_state)
                S_IDLE: begin
                    if (cal_start) begin
                        r_tap        <= 5'd0;
                        r_cal_busy   <= 1'b1;
                        r_cal_done   <= 1'b0;
                        r_cal_fail   <= 1'b0;
                        r_pass_map   <= 32'd0;
                        r_cur_start  <= 5'd0;
                        r_cur_len    <= 6'd0;
                        r_best_start <= 5'd0;
                        r_best_len   <= 6'd0;
                    end
                end
                S_LOAD: begin
                    r_tap_ok     <= 1'b1;
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + SW'(1);
                    if (w_settle_last) begin
                        if (w_rb_bad) r_tap_ok <= 1'b0;
                        r_to_cnt   <= '0;
                        r_beat_cnt <= '0;
                    end
                end
                S_REQ: begin
                    // Hold the count on ack so CHECK never starts past the limit
                    if (!rd_ack) begin
                        if (w_to_hit)
                            r_tap_ok <= 1'b0;
                        else
                            r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (rd_beat_valid) begin
                        r_to_cnt   <= '0;
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        if (!w_beat_ok) r_tap_ok <= 1'b0;
                    end else if (w_to_hit) begin
                        r_tap_ok <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_NEXT: begin
                    r_pass_map[r_tap] <= r_tap_ok;
                    r_cur_start       <= w_cur_start_nxt;
                    r_cur_len         <= w_cur_len_nxt;
                    // Strictly greater keeps the earliest of equal windows
                    if (w_cur_len_nxt > r_best_len) begin
                        r_best_start <= w_cur_start_nxt;
                        r_best_len   <= w_cur_len_nxt;
                    end
                    if (!w_last_tap) r_tap <= r_tap + 5'd1;
                end
                S_FINAL: begin
                    r_cal_tap  <= w_final_tap;
                    r_cal_fail <= (r_best_len == 6'd0);
                end
                S_DONE: begin
                    r_cal_busy <= 1'b0;
                    r_cal_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cal_busy      = r_cal_busy;
    assign cal_done      = r_cal_done;
    assign cal_fail      = r_cal_fail;
    assign cal_tap       = r_cal_tap;
    assign pass_map      = r_pass_map;
    assign v_dlyval_dqs  = w_dlyval;
    assign v_dlyld_dqs   = w_dlyld;
    assign v_dq_iddr_rst = w_iddr_rst;
    assign rd_req        = w_rd_req;

endmodule

// File: tb/tb_nand_dqs_calib_ctrl.sv
// Directed bench for nand_dqs_calib_ctrl with a PHY/controller responder.
// Each scenario task drives a sweep and checks hand-computed results.
module tb_nand_dqs_calib_ctrl;

    logic        v_clk0 = 1'b0;
    logic        v_rstn0 = 1'b0;
    logic        cal_start = 1'b0;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [4:0]  cal_tap;
    logic [31:0] pass_map;
    logic [4:0]  v_dlyval_dqs;
    logic        v_dlyld_dqs;
    logic [4:0]  v_dlyvalout_dqs;
    logic        v_dq_iddr_rst;
    logic        rd_req;
    logic        rd_ack = 1'b0;
    logic        rd_beat_valid = 1'b0;
    logic [7:0]  v_rd_data_rise = 8'h00;
    logic [7:0]  v_rd_data_fall = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [31:0] good_mask = 32'hFFFF_FFFF;
    int          noack_tap = -1;
    int          rb_bad_tap = -1;
    int          n_beats = 4;
    logic [4:0]  phy_tap = 5'd0;
    logic [4:0]  last_ld = 5'd0;
    logic [4:0]  first_ld = 5'd0;
    int          mst = 0;
    int          bcnt = 0;
    int          n_ld = 0;
    int          n_iddr = 0;
    int          n_req_noack = 0;

    nand_dqs_calib_ctrl dut (
        .v_clk0          (v_clk0),
        .v_rstn0         (v_rstn0),
        .cal_start       (cal_start),
        .cal_busy        (cal_busy),
        .cal_done        (cal_done),
        .cal_fail        (cal_fail),
        .cal_tap         (cal_tap),
        .pass_map        (pass_map),
        .v_dlyval_dqs    (v_dlyval_dqs),
        .v_dlyld_dqs     (v_dlyld_dqs),
        .v_dlyvalout_dqs (v_dlyvalout_dqs),
        .v_dq_iddr_rst   (v_dq_iddr_rst),
        .rd_req          (rd_req),
        .rd_ack          (rd_ack),
        .rd_beat_valid   (rd_beat_valid),
        .v_rd_data_rise  (v_rd_data_rise),
        .v_rd_data_fall  (v_rd_data_fall)
    );

    always #5 v_clk0 = ~v_clk0;

    assign v_dlyvalout_dqs = (int'(phy_tap) == rb_bad_tap) ?
                             (phy_tap ^ 5'd1) : phy_tap;

    // PHY delay line plus controller: ack two cycles after rd_req, then beats
    initial begin
        forever begin
            @(negedge v_clk0);
            rd_ack = 1'b0;
            rd_beat_valid = 1'b0;
            v_rd_data_rise = 8'h00;
            v_rd_data_fall = 8'h00;
            if (!v_rstn0) begin
                mst = 0;
            end else begin
                if (v_dlyld_dqs) begin
                    phy_tap = v_dlyval_dqs;
                    last_ld = v_dlyval_dqs;
                    if (n_ld == 0) first_ld = v_dlyval_dqs;
                    n_ld++;
                end
                if (v_dq_iddr_rst) n_iddr++;
                if (rd_req && int'(phy_tap) == noack_tap) n_req_noack++;
                case (mst)
                    0: begin
                        if (rd_req && int'(phy_tap) != noack_tap) mst = 1;
                    end
                    1: begin
                        rd_ack = 1'b1;
                        bcnt = 0;
                        mst = 2;
                    end
                    default: begin
                        rd_beat_valid = 1'b1;
                        if (bcnt < 4) begin
                            v_rd_data_rise = good_mask[phy_tap] ? 8'hA5 : 8'hA4;
                            v_rd_data_fall = 8'h5A;
                        end
                        bcnt++;
                        if (bcnt >= n_beats) mst = 0;
                    end
                endcase
            end
        end
    end

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge v_clk0);
            if (cal_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: cal_done=0 after 5000 cycles, required 1", tag);
        end
    endtask

    task automatic start_sweep(input logic [31:0] mask, input int noack,
                               input int rbbad, input int nb);
        good_mask = mask;
        noack_tap = noack;
        rb_bad_tap = rbbad;
        n_beats = nb;
        n_ld = 0;
        n_iddr = 0;
        n_req_noack = 0;
        @(negedge v_clk0);
        cal_start = 1'b1;
        @(negedge v_clk0);
        cal_start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge v_clk0);
        checks++;
        if (cal_tap !== 5'd16 || v_dlyval_dqs !== 5'd16) begin
            errors++;
            $display("FAIL reset_taps: cal_tap=%0d dlyval=%0d, required 16/16",
                     cal_tap, v_dlyval_dqs);
        end
        checks++;
        if ({cal_busy, cal_done, cal_fail, v_dlyld_dqs, v_dq_iddr_rst, rd_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done/fail/ld/iddr/req=%b, required 000000",
                     {cal_busy, cal_done, cal_fail, v_dlyld_dqs, v_dq_iddr_rst, rd_req});
        end
        checks++;
        if (pass_map !== 32'h0) begin
            errors++;
            $display("FAIL reset_map: pass_map=%h, required 00000000", pass_map);
        end
        v_rstn0 = 1'b1;
        repeat (3) @(negedge v_clk0);
        checks++;
        if (cal_busy !== 1'b0 || v_dlyld_dqs !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ld=%b, required 0/0", cal_busy, v_dlyld_dqs);
        end
    endtask

    task automatic test_all_pass;
        start_sweep(32'hFFFF_FFFF, -1, -1, 4);
        checks++;
        if (cal_busy !== 1'b1) begin
            errors++;
            $display("FAIL allpass_busy: cal_busy=%b, required 1", cal_busy);
        end
        wait_done("allpass");
        checks++;
        if (pass_map !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL allpass_map: pass_map=%h, required ffffffff", pass_map);
        end
        checks++;
        if (cal_tap !== 5'd15 || cal_fail !== 1'b0) begin
            errors++;
            $display("FAIL allpass_tap: cal_tap=%0d fail=%b, required 15/0", cal_tap, cal_fail);
        end
        checks++;
        if (n_ld != 33 || n_iddr != 32) begin
            errors++;
            $display("FAIL allpass_pulses: dlyld=%0d iddr=%0d, required 33/32", n_ld, n_iddr);
        end
        checks++;
        if (v_dlyval_dqs !== 5'd15 || last_ld !== 5'd15 || cal_busy !== 1'b0) begin
            errors++;
            $display("FAIL allpass_final: dlyval=%0d last_ld=%0d busy=%b, required 15/15/0",
                     v_dlyval_dqs, last_ld, cal_busy);
        end
    endtask

    task automatic test_window;
        start_sweep(32'h00F0_03FC, -1, -1, 5);
        wait_done("window");
        checks++;
        if (pass_map !== 32'h00F0_03FC) begin
            errors++;
            $display("FAIL window_map: pass_map=%h, required 00f003fc", pass_map);
        end
        checks++;
        if (cal_tap !== 5'd5 || cal_fail !== 1'b0) begin
            errors++;
            $display("FAIL window_tap: cal_tap=%0d fail=%b, required 5/0", cal_tap, cal_fail);
        end
    endtask

    task automatic test_tie_and_single;
        start_sweep(32'h00F0_00F0, -1, -1, 4);
        wait_done("tie");
        checks++;
        if (cal_tap !== 5'd5 || pass_map !== 32'h00F0_00F0) begin
            errors++;
            $display("FAIL tie_tap: cal_tap=%0d map=%h, required 5/00f000f0", cal_tap, pass_map);
        end
        start_sweep(32'h8000_0000, -1, -1, 4);
        wait_done("single");
        checks++;
        if (cal_tap !== 5'd31 || cal_fail !== 1'b0 || pass_map !== 32'h8000_0000) begin
            errors++;
            $display("FAIL single_tap: cal_tap=%0d fail=%b map=%h, required 31/0/80000000",
                     cal_tap, cal_fail, pass_map);
        end
    endtask

    task automatic test_all_fail;
        start_sweep(32'h0, -1, -1, 4);
        wait_done("allfail");
        checks++;
        if (cal_fail !== 1'b1 || cal_tap !== 5'd16) begin
            errors++;
            $display("FAIL allfail_tap: fail=%b cal_tap=%0d, required 1/16", cal_fail, cal_tap);
        end
        checks++;
        if (last_ld !== 5'd16 || v_dlyval_dqs !== 5'd16 || pass_map !== 32'h0) begin
            errors++;
            $display("FAIL allfail_load: last_ld=%0d dlyval=%0d map=%h, required 16/16/0",
                     last_ld, v_dlyval_dqs, pass_map);
        end
    endtask

    task automatic test_timeout;
        start_sweep(32'hFFFF_FFFF, 7, -1, 4);
        wait_done("timeout");
        checks++;
        if (n_req_noack != 255) begin
            errors++;
            $display("FAIL timeout_req: rd_req cycles=%0d at tap 7, required 255", n_req_noack);
        end
        checks++;
        if (pass_map !== 32'hFFFF_FF7F || cal_tap !== 5'd19) begin
            errors++;
            $display("FAIL timeout_tap: map=%h cal_tap=%0d, required ffffff7f/19",
                     pass_map, cal_tap);
        end
    endtask

    task automatic test_readback;
        start_sweep(32'hFFFF_FFFF, -1, 3, 4);
        wait_done("readback");
        checks++;
        if (pass_map !== 32'hFFFF_FFF7 || cal_tap !== 5'd17) begin
            errors++;
            $display("FAIL readback_tap: map=%h cal_tap=%0d, required fffffff7/17",
                     pass_map, cal_tap);
        end
    endtask

    task automatic test_start_ignored;
        start_sweep(32'hFFFF_FFFF, -1, -1, 4);
        repeat (200) @(negedge v_clk0);
        checks++;
        if (cal_busy !== 1'b1 || cal_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy: busy=%b done=%b, required 1/0", cal_busy, cal_done);
        end
        cal_start = 1'b1;
        @(negedge v_clk0);
        cal_start = 1'b0;
        wait_done("restart");
        checks++;
        if (n_ld != 33 || cal_tap !== 5'd15 || pass_map !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL restart_sweep: dlyld=%0d cal_tap=%0d map=%h, required 33/15/ffffffff",
                     n_ld, cal_tap, pass_map);
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        hit = 1'b0;
        start_sweep(32'hFFFF_FFFF, -1, -1, 4);
        for (int i = 0; i < 2000; i++) begin
            @(negedge v_clk0);
            #1;
            if (phy_tap == 5'd10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || v_dlyld_dqs !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reach: tap10 seen=%b ld=%b, required 1/1", hit, v_dlyld_dqs);
        end
        v_rstn0 = 1'b0;
        #1;
        checks++;
        if ({cal_busy, cal_done, cal_fail, v_dlyld_dqs, v_dq_iddr_rst, rd_req} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_flags: busy/done/fail/ld/iddr/req=%b, required 000000",
                     {cal_busy, cal_done, cal_fail, v_dlyld_dqs, v_dq_iddr_rst, rd_req});
        end
        checks++;
        if (v_dlyval_dqs !== 5'd16 || cal_tap !== 5'd16 || pass_map !== 32'h0) begin
            errors++;
            $display("FAIL midrst_vals: dlyval=%0d cal_tap=%0d map=%h, required 16/16/0",
                     v_dlyval_dqs, cal_tap, pass_map);
        end
        repeat (2) @(negedge v_clk0);
        #1;
        v_rstn0 = 1'b1;
        repeat (2) @(negedge v_clk0);
        start_sweep(32'hFFFF_FFFF, -1, -1, 4);
        wait_done("midrst");
        checks++;
        if (first_ld !== 5'd0 || n_ld != 33 || cal_tap !== 5'd15) begin
            errors++;
            $display("FAIL midrst_sweep: first_ld=%0d dlyld=%0d cal_tap=%0d, required 0/33/15",
                     first_ld, n_ld, cal_tap);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_window();
        test_tie_and_single();
        test_all_fail();
        test_timeout();
        test_readback();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_dqs_calib_ctrl.md
Name: nand_dqs_calib_ctrl

Overview:
- Read-capture calibration sequencer for one NAND PHY channel (x8 DQ, one DQS).
- Sweeps the DQS IDELAY tap and loads each tap through the PHY's dlyval/dlyld port.
- At each tap, asks the flash controller for a known-pattern read burst and checks the captured rise/fall data.
- After the sweep, loads the centre of the longest contiguous passing window. Sits between the flash controller and the PHY and owns the DQS delay port while busy.

Parameters:
DQ_WIDTH, 8, data bus width
NUM_TAPS, 32, taps swept (0..NUM_TAPS-1), max 32
SETTLE_CYCLES, 16, wait cycles after each tap load
BEATS, 4, rise/fall beat pairs checked per tap
PAT_RISE, 8'hA5, expected rise data
PAT_FALL, 8'h5A, expected fall data
TIMEOUT, 255, max cycles waiting for ack or beats before the tap is failed
DEFAULT_TAP, 16, tap loaded when no tap passes

Ports:
v_clk0  in  1  clock (PHY clk0 domain)
v_rstn0  in  1  reset, asynchronous, active-low
cal_start  in  1  one-cycle start pulse
cal_busy  out  1  sweep in progress
cal_done  out  1  result valid; sticky until next accepted start
cal_fail  out  1  no passing tap found; valid with cal_done
cal_tap  out  5  tap finally loaded
pass_map  out  32  bit i = tap i passed; bits >= NUM_TAPS are 0
v_dlyval_dqs  out  5  tap value to PHY
v_dlyld_dqs  out  1  one-cycle load strobe to PHY
v_dlyvalout_dqs  in  5  tap readback from PHY
v_dq_iddr_rst  out  1  IDDR reset to PHY
rd_req  out  1  pattern-read request to controller
rd_ack  in  1  one-cycle acceptance of rd_req
rd_beat_valid  in  1  rise/fall data valid this cycle
v_rd_data_rise  in  DQ_WIDTH  captured rise data
v_rd_data_fall  in  DQ_WIDTH  captured fall data

Behaviour:
- Reset values: all outputs 0 except v_dlyval_dqs = DEFAULT_TAP, cal_tap = DEFAULT_TAP. FSM goes to IDLE. Reset is honoured mid-sweep, with no final load.
- IDLE: cal_start moves to LOAD with tap = 0. At the same time, cal_done, cal_fail, pass_map and the window registers clear, and cal_busy is set the next cycle. cal_start while busy is ignored.
- LOAD (1 cycle): v_dlyval_dqs = tap, v_dlyld_dqs = 1, v_dq_iddr_rst = 1. Go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles. In the final cycle, compare v_dlyvalout_dqs with tap; a mismatch marks the tap failed. Go to REQ.
- REQ: rd_req is held high until rd_ack is seen, then drops the following cycle. Go to CHECK.
- CHECK: count rd_beat_valid cycles up to BEATS. A beat fails if rise != PAT_RISE or fall != PAT_FALL.
- Tap pass condition: readback matched, all BEATS beats matched, and no timeout. Beats arriving after BEATS are counted are ignored.
- Timeout: a single counter, reset on entry to REQ and on each beat. Reaching TIMEOUT in REQ or CHECK fails the tap and goes to NEXT; rd_req drops at once.
- NEXT (1 cycle):
  - Write pass_map[tap].
  - Window update: on pass, if cur_len == 0 then cur_start = tap; cur_len += 1. On fail, cur_len = 0.
  - After the update, if cur_len > best_len (strictly greater, so the earliest window wins a tie), then best_start = cur_start and best_len = cur_len.
  - If tap == NUM_TAPS-1 go to FINAL, else tap += 1 and go to LOAD.
  - Window counters are 6 bits wide.
- FINAL (1 cycle):
  - If best_len == 0: cal_tap = DEFAULT_TAP, cal_fail = 1.
  - Else: cal_tap = best_start + ((best_len-1) >> 1), i.e. the floor of the centre.
  - v_dlyval_dqs = cal_tap and v_dlyld_dqs = 1. Go to DONE.
- DONE (1 cycle): cal_busy = 0 and cal_done = 1 (both registered). Go to IDLE.
- v_dlyld_dqs is high only in LOAD and FINAL. v_dlyval_dqs holds its last value otherwise.
- Sweep latency per tap without timeouts: 1 + SETTLE_CYCLES + ack wait + beat time + 1 cycles.

Test Plan:
- PHY model passes every tap, ack after 2 cycles, 4 good beats -> pass_map = 32'hFFFFFFFF, cal_tap = 15, cal_fail = 0, exactly 33 dlyld pulses.
- Passing taps 2..9 and 20..23 -> best window 2..9, cal_tap = 5, pass_map = 32'h00F003FC.
- Equal windows 4..7 and 20..23 -> first window kept, cal_tap = 5. Single passing tap 31 -> cal_tap = 31.
- All beats corrupt (rise = 8'hA4) -> cal_fail = 1, cal_tap = 16, final v_dlyval_dqs = 16, pass_map = 0.
- Controller never acks at tap 7 (other taps pass) -> rd_req drops after 255 cycles, tap 7 fails, windows 0..6 and 8..31, cal_tap = 19. A readback mismatch at tap 3 likewise fails only tap 3.
- cal_start pulsed mid-sweep -> ignored. v_rstn0 low at tap 10 -> all outputs back to reset values immediately and cal_done = 0. A new start then runs a full sweep from tap 0.
